gram64_arbiter: RTL and testbench

- Shares one gram64 (64 x 16-bit, synchronous write, combinational read) between two requesters, port A and port B, with round-robin arbitration.
- Adds a bulk-clear sequencer that writes CLEAR_VALUE to every word, locking out both requesters while it runs.
- Sits between gram64 and its users, e.g. the CPU data path and a loader.

---
 rtl/gram64_arbiter_pkg.sv | 19 +
 rtl/gram64_arbiter_rr_arb2.sv | 43 ++++
 rtl/gram64_arbiter.sv | 117 +++++++++++
 tb/tb_gram64_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/gram64_arbiter_pkg.sv
// gram64_arbiter shared constants and types.
// Word/address sizing, FSM states and port selects.
package gram64_arbiter_pkg;

  localparam int WIDTH  = 16;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } state_t;

  typedef enum logic {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } sel_t;

endpackage

// File: rtl/gram64_arbiter_rr_arb2.sv
// Two-way round-robin grant logic.
// Holds the last winner so a tie goes to the other port.
module gram64_arbiter_rr_arb2
  import gram64_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  sel_t last_q;

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (en) begin
      unique case (1'b1)
        (req_a && req_b): begin
          gnt_a = (last_q == SEL_B);
          gnt_b = (last_q == SEL_A);
        end
        (req_a && !req_b): gnt_a = 1'b1;
        (!req_a && req_b): gnt_b = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= SEL_B;
    end else if (gnt_a) begin
      last_q <= SEL_A;
    end else if (gnt_b) begin
      last_q <= SEL_B;
    end
  end

endmodule

// File: rtl/gram64_arbiter.sv
// Two-port round-robin front end for gram64.
// Adds a bulk-clear sequencer that locks out both ports.
module gram64_arbiter #(
  parameter int WIDTH  = gram64_arbiter_pkg::WIDTH,
  parameter int ADDR_W = gram64_arbiter_pkg::ADDR_W,
  parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [WIDTH-1:0]  a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [WIDTH-1:0]  a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [WIDTH-1:0]  b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [WIDTH-1:0]  b_rdata,
  input  logic              start_clear,
  output logic              busy,
  output logic              clear_done,
  output logic [WIDTH-1:0]  mem_w,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_load,
  input  logic [WIDTH-1:0]  mem_out_w
);

  import gram64_arbiter_pkg::*;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              done_d;
  logic              arb_en;

  // A clear request steals its own cycle from both ports.
  assign arb_en = (state_q == ARB) && !start_clear;
  assign busy   = (state_q == CLEAR);

  gram64_arbiter_rr_arb2 u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (arb_en),
    .req_a (a_req),
    .req_b (b_req),
    .gnt_a (a_gnt),
    .gnt_b (b_gnt)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    mem_load    = 1'b0;
    mem_address = '0;
    mem_w       = '0;
    unique case (state_q)
      ARB: begin
        if (start_clear) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
        if (a_gnt) begin
          mem_address = a_addr;
          mem_load    = a_we;
          mem_w       = a_we ? a_wdata : '0;
        end else if (b_gnt) begin
          mem_address = b_addr;
          mem_load    = b_we;
          mem_w       = b_we ? b_wdata : '0;
        end
      end
      CLEAR: begin
        mem_load    = 1'b1;
        mem_address = cnt_q;
        mem_w       = CLEAR_VALUE;
        cnt_d       = cnt_q + ADDR_W'(1);
        if (cnt_q == {ADDR_W{1'b1}}) begin
          state_d = ARB;
          done_d  = 1'b1;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB;
      cnt_q      <= '0;
      clear_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clear_done <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= a_gnt && !a_we;
      b_rvalid <= b_gnt && !b_we;
      if (a_gnt && !a_we) a_rdata <= mem_out_w;
      if (b_gnt && !b_we) b_rdata <= mem_out_w;
    end
  end

endmodule

// File: tb/tb_gram64_arbiter.sv
// Directed bench for gram64_arbiter with a behavioural gram64.
// Vector table for arbitration, hand sequences for clear and reset.
module tb_gram64_arbiter;

  localparam bit H = 1'b1;
  localparam bit L = 1'b0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_req, a_we, b_req, b_we;
  logic [5:0]  a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [15:0] a_rdata, b_rdata;
  logic        start_clear, busy, clear_done;
  logic [15:0] mem_w, mem_out_w;
  logic [5:0]  mem_address;
  logic        mem_load;

  always #5 clk = ~clk;

  gram64_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a_req       (a_req),
    .a_we        (a_we),
    .a_addr      (a_addr),
    .a_wdata     (a_wdata),
    .a_gnt       (a_gnt),
    .a_rvalid    (a_rvalid),
    .a_rdata     (a_rdata),
    .b_req       (b_req),
    .b_we        (b_we),
    .b_addr      (b_addr),
    .b_wdata     (b_wdata),
    .b_gnt       (b_gnt),
    .b_rvalid    (b_rvalid),
    .b_rdata     (b_rdata),
    .start_clear (start_clear),
    .busy        (busy),
    .clear_done  (clear_done),
    .mem_w       (mem_w),
    .mem_address (mem_address),
    .mem_load    (mem_load),
    .mem_out_w   (mem_out_w)
  );

  logic [15:0] mem [64];
  always @(posedge clk) if (mem_load) mem[mem_address] <= mem_w;
  assign mem_out_w = mem[mem_address];

  int total = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  typedef struct {
    logic ar, aw; logic [5:0] aad; logic [15:0] awd;
    logic br, bw; logic [5:0] bad; logic [15:0] bwd;
    logic eag, ebg;
    logic earv; logic [15:0] eard;
    logic ebrv; logic [15:0] ebrd;
  } vec_t;

  vec_t tbl[$];

  task automatic v(input logic ar, aw, input logic [5:0] aad,
                   input logic [15:0] awd,
                   input logic br, bw, input logic [5:0] bad,
                   input logic [15:0] bwd,
                   input logic eag, ebg,
                   input logic earv, input logic [15:0] eard,
                   input logic ebrv, input logic [15:0] ebrd);
    vec_t t;
    t.ar = ar; t.aw = aw; t.aad = aad; t.awd = awd;
    t.br = br; t.bw = bw; t.bad = bad; t.bwd = bwd;
    t.eag = eag; t.ebg = ebg;
    t.earv = earv; t.eard = eard;
    t.ebrv = ebrv; t.ebrd = ebrd;
    tbl.push_back(t);
  endtask

  task automatic idle();
    a_req = L; a_we = L; a_addr = '0; a_wdata = '0;
    b_req = L; b_we = L; b_addr = '0; b_wdata = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic op(input logic pb, input logic we,
                    input logic [5:0] ad, input logic [15:0] d,
                    input string nm);
    logic got;
    got = L;
    if (!pb) begin a_req = H; a_we = we; a_addr = ad; a_wdata = d; end
    else     begin b_req = H; b_we = we; b_addr = ad; b_wdata = d; end
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      got = pb ? b_gnt : a_gnt;
      step();
    end
    chk({nm, "_gnt"}, 32'(got), 32'd1);
    idle();
  endtask

  int busy_cnt, done_cnt, gnt_bad;

  initial begin
    idle();
    start_clear = L;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(clear_done), 32'd0);
    chk("rst_rv", {a_rvalid, b_rvalid}, 32'd0);
    chk("rst_rdata", {a_rdata, b_rdata}, 32'd0);
    chk("rst_gnt", {a_gnt, b_gnt}, 32'd0);
    chk("rst_mem", {mem_load, mem_address, mem_w}, 32'd0);
    @(negedge clk); rst_n = H;
    step();

    // reset leaves last_grant=B, so A wins the first tie
    v(H,H,6'd5,16'hAAAA, L,L,6'd0,16'h0,    H,L, L,16'h0,    L,16'h0);
    v(L,L,6'd0,16'h0,    L,L,6'd0,16'h0,    L,L, L,16'h0,    L,16'h0);
    v(H,L,6'd5,16'h0,    L,L,6'd0,16'h0,    H,L, L,16'h0,    L,16'h0);
    v(L,L,6'd0,16'h0,    H,L,6'd5,16'h0,    L,H, H,16'hAAAA, L,16'h0);
    v(L,L,6'd0,16'h0,    L,L,6'd0,16'h0,    L,L, L,16'hAAAA, H,16'hAAAA);
    v(H,H,6'd1,16'h1111, H,H,6'd2,16'h2222, H,L, L,16'hAAAA, L,16'hAAAA);
    v(H,H,6'd1,16'h3333, H,H,6'd2,16'h2222, L,H, L,16'hAAAA, L,16'hAAAA);
    v(H,H,6'd1,16'h3333, H,H,6'd2,16'h4444, H,L, L,16'hAAAA, L,16'hAAAA);
    v(H,L,6'd1,16'h0,    H,H,6'd2,16'h4444, L,H, L,16'hAAAA, L,16'hAAAA);
    v(H,L,6'd1,16'h0,    H,L,6'd2,16'h0,    H,L, L,16'hAAAA, L,16'hAAAA);
    v(L,L,6'd0,16'h0,    H,L,6'd2,16'h0,    L,H, H,16'h3333, L,16'hAAAA);
    v(L,L,6'd0,16'h0,    L,L,6'd0,16'h0,    L,L, L,16'h3333, H,16'h4444);
    v(H,H,6'd0,16'h1234, L,L,6'd0,16'h0,    H,L, L,16'h3333, L,16'h4444);
    v(L,L,6'd0,16'h0,    H,H,6'd63,16'hFFFF,L,H, L,16'h3333, L,16'h4444);
    v(H,L,6'd0,16'h0,    H,L,6'd63,16'h0,   H,L, L,16'h3333, L,16'h4444);
    v(L,L,6'd0,16'h0,    H,L,6'd63,16'h0,   L,H, H,16'h1234, L,16'h4444);
    v(L,L,6'd0,16'h0,    L,L,6'd0,16'h0,    L,L, L,16'h1234, H,16'hFFFF);

    foreach (tbl[i]) begin
      a_req = tbl[i].ar; a_we = tbl[i].aw;
      a_addr = tbl[i].aad; a_wdata = tbl[i].awd;
      b_req = tbl[i].br; b_we = tbl[i].bw;
      b_addr = tbl[i].bad; b_wdata = tbl[i].bwd;
      chk($sformatf("v%0d_a_rvalid", i), 32'(a_rvalid), 32'(tbl[i].earv));
      chk($sformatf("v%0d_a_rdata", i), 32'(a_rdata), 32'(tbl[i].eard));
      chk($sformatf("v%0d_b_rvalid", i), 32'(b_rvalid), 32'(tbl[i].ebrv));
      chk($sformatf("v%0d_b_rdata", i), 32'(b_rdata), 32'(tbl[i].ebrd));
      @(negedge clk);
      chk($sformatf("v%0d_a_gnt", i), 32'(a_gnt), 32'(tbl[i].eag));
      chk($sformatf("v%0d_b_gnt", i), 32'(b_gnt), 32'(tbl[i].ebg));
      step();
    end
    idle();

    // bulk clear with A read of addr 0 pending throughout
    a_req = H; a_we = L; a_addr = 6'd0;
    start_clear = H;
    @(negedge clk);
    chk("clr_start_gnt", {a_gnt, b_gnt}, 32'd0);
    step();
    start_clear = L;
    busy_cnt = 0; done_cnt = 0; gnt_bad = 0;
    for (int i = 0; i < 200 && busy; i++) begin
      if (a_gnt || b_gnt) gnt_bad++;
      if (clear_done) done_cnt++;
      if (i == 10) start_clear = H;
      if (i == 11) start_clear = L;
      busy_cnt++;
      step();
    end
    chk("clr_busy_cycles", busy_cnt, 64);
    chk("clr_gnt_while_busy", gnt_bad, 0);
    chk("clr_done_early", done_cnt, 0);
    chk("clr_busy_end", 32'(busy), 32'd0);
    chk("clr_done_pulse", 32'(clear_done), 32'd1);
    chk("clr_first_gnt", 32'(a_gnt), 32'd1);
    step();
    idle();
    chk("clr_done_once", 32'(clear_done), 32'd0);
    chk("clr_rd0_valid", 32'(a_rvalid), 32'd1);
    chk("clr_rd0", 32'(a_rdata), 32'd0);
    op(H, L, 6'd63, 16'h0, "clr_rd63");
    chk("clr_rd63", 32'(b_rdata), 32'd0);

    // reset in the middle of a clear
    op(L, H, 6'd30, 16'h3030, "pre_w30");
    op(H, H, 6'd10, 16'h1010, "pre_w10");
    op(L, L, 6'd30, 16'h0, "pre_r30");
    chk("pre_rd30", 32'(a_rdata), 32'h3030);
    start_clear = H;
    step();
    start_clear = L;
    repeat (20) step();
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_addr", 32'(mem_address), 32'd20);
    rst_n = L;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rdata", {a_rdata, b_rdata}, 32'd0);
    chk("abort_load", 32'(mem_load), 32'd0);
    @(negedge clk); rst_n = H;
    step();
    op(L, L, 6'd30, 16'h0, "post_r30");
    chk("post_rd30", 32'(a_rdata), 32'h3030);
    op(H, L, 6'd10, 16'h0, "post_r10");
    chk("post_rd10", 32'(b_rdata), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
